// File: rtl/ics1_replay_queue_pkg.sv
// Shared definitions for the stage-1 instruction-cache replay controller:
// FSM state encoding, default address width and the counter-width helper.
package ics1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MISS   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    localparam int ICS1_ADDR_WIDTH = 16;

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ics1_replay_queue_if.sv
// Request/issue handshake between fetch, the replay controller and stage 2.
// Signal names are given from the controller's point of view.
interface ics1_replay_queue_if
    import ics1_pkg::*;
#(
    parameter int ADDR_WIDTH = ICS1_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] i_curr_r_addr;
    logic                  i_curr_r_addr_valid;
    logic                  o_curr_r_addr_ready;
    logic [ADDR_WIDTH-1:0] o_r_addr;
    logic                  o_r_addr_valid;
    logic                  o_replaying;

    modport master (
        output i_curr_r_addr,
        output i_curr_r_addr_valid,
        input  o_curr_r_addr_ready,
        input  o_r_addr,
        input  o_r_addr_valid,
        input  o_replaying
    );

    modport slave (
        input  i_curr_r_addr,
        input  i_curr_r_addr_valid,
        output o_curr_r_addr_ready,
        output o_r_addr,
        output o_r_addr_valid,
        output o_replaying
    );
endinterface

// File: rtl/ics1_replay_queue_buf.sv
// Snapshot storage for the replay controller. On a load strobe the valid
// in-flight slices are packed, oldest first, into the low entries and the
// number of valid slices is recorded. Entries are read by index.
module ics1_replay_buf
    import ics1_pkg::*;
#(
    parameter int ADDR_WIDTH   = ICS1_ADDR_WIDTH,
    parameter int REPLAY_DEPTH = 2,
    localparam int CW          = cnt_width(REPLAY_DEPTH)
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               i_load,
    input  logic [REPLAY_DEPTH*ADDR_WIDTH-1:0] i_inflight_addr,
    input  logic [REPLAY_DEPTH-1:0]            i_inflight_valid,
    input  logic [CW-1:0]                      i_rd_idx,
    output logic [ADDR_WIDTH-1:0]              o_rd_addr,
    output logic [CW-1:0]                      o_snap_cnt
);
    logic [REPLAY_DEPTH*ADDR_WIDTH-1:0] r_snap;
    logic [REPLAY_DEPTH*ADDR_WIDTH-1:0] w_comp;
    logic [CW-1:0]                      r_snap_cnt;
    logic [CW-1:0]                      w_cnt;

    // Compact valid slices into consecutive slots and count them.
    always_comb begin
        int pos;
        pos    = 0;
        w_comp = '0;
        for (int i = 0; i < REPLAY_DEPTH; i++) begin
            if (i_inflight_valid[i]) begin
                for (int k = 0; k < REPLAY_DEPTH; k++) begin
                    if (pos == k) begin
                        w_comp[k*ADDR_WIDTH +: ADDR_WIDTH] = i_inflight_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
                pos = pos + 1;
            end
        end
        w_cnt = CW'(pos);
    end

    // Indexed read mux over the snapshot entries.
    always_comb begin
        o_rd_addr = '0;
        for (int k = 0; k < REPLAY_DEPTH; k++) begin
            if (i_rd_idx == CW'(k)) begin
                o_rd_addr = r_snap[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Snapshot register: replaced wholesale on every load.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_snap     <= '0;
            r_snap_cnt <= '0;
        end else if (i_load) begin
            r_snap     <= w_comp;
            r_snap_cnt <= w_cnt;
        end
    end

    assign o_snap_cnt = r_snap_cnt;

endmodule

// File: rtl/ics1_replay_queue.sv
// Stage-1 restart/replay controller for the instruction cache read path.
// Blocks issue while a miss is serviced, then replays the addresses that
// were in flight at miss entry (oldest first, one per cycle) before going
// back to passing the fetch request stream through.
// Optional build macro ICS1_REPLAY_STATS_EN adds saturating miss/replay
// counters on o_stat_miss_cnt / o_stat_replay_cnt.
//
// state  | meaning
// IDLE   | pass-through of the current fetch request
// MISS   | cache miss in service, nothing issues
// REPLAY | issuing snapshot entries 1..snap_cnt-1 (entry 0 issues on MISS exit)
module ics1_replay_queue
    import ics1_pkg::*;
#(
    parameter int ADDR_WIDTH   = ICS1_ADDR_WIDTH,
    parameter int REPLAY_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               i_halt,
    input  logic [REPLAY_DEPTH*ADDR_WIDTH-1:0] i_inflight_addr,
    input  logic [REPLAY_DEPTH-1:0]            i_inflight_valid,
    input  logic                               i_miss_state,
    ics1_replay_queue_if.slave                 io_fetch
`ifdef ICS1_REPLAY_STATS_EN
    ,
    output logic [15:0]                        o_stat_miss_cnt,
    output logic [15:0]                        o_stat_replay_cnt
`endif
);
    localparam int CW = cnt_width(REPLAY_DEPTH);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         w_rd_ptr_nxt;
    logic                  w_capture;
    logic                  w_replay_issue;
    logic [CW-1:0]         w_snap_cnt;
    logic [ADDR_WIDTH-1:0] w_snap_addr;
    logic [ADDR_WIDTH-1:0] w_r_addr;
    logic                  w_r_addr_valid;
    logic                  w_ready;
    logic                  w_replaying;

    ics1_replay_buf #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .REPLAY_DEPTH (REPLAY_DEPTH)
    ) u_buf (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_load           (w_capture & ~i_halt),
        .i_inflight_addr  (i_inflight_addr),
        .i_inflight_valid (i_inflight_valid),
        .i_rd_idx         (r_rd_ptr),
        .o_rd_addr        (w_snap_addr),
        .o_snap_cnt       (w_snap_cnt)
    );

    // Next state, replay pointer and snapshot capture decision.
    always_comb begin
        w_next       = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_miss_state) begin
                    w_next    = ST_MISS;
                    w_capture = 1'b1;
                end
            end
            ST_MISS: begin
                if (!i_miss_state) begin
                    // Entry 0 issues on this exit cycle, so REPLAY starts at entry 1.
                    if (w_snap_cnt > CW'(1)) begin
                        w_next       = ST_REPLAY;
                        w_rd_ptr_nxt = CW'(1);
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_REPLAY: begin
                if (i_miss_state) begin
                    w_next    = ST_MISS;
                    w_capture = 1'b1;
                end else if (r_rd_ptr == w_snap_cnt - CW'(1)) begin
                    w_next       = ST_IDLE;
                    w_rd_ptr_nxt = '0;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr + CW'(1);
                end
            end
            default: begin
                w_next       = ST_IDLE;
                w_rd_ptr_nxt = '0;
            end
        endcase
        if (w_capture) begin
            w_rd_ptr_nxt = '0;
        end
    end

    // Output mux: block on a miss, otherwise replay or pass the request through.
    always_comb begin
        w_replay_issue = ((r_state == ST_MISS) && !i_miss_state && (w_snap_cnt != '0)) ||
                         ((r_state == ST_REPLAY) && !i_miss_state);
        w_r_addr       = '0;
        w_r_addr_valid = 1'b0;
        w_ready        = 1'b0;
        w_replaying    = 1'b0;
        if (w_next == ST_MISS) begin
            w_r_addr       = '0;
        end else if (w_replay_issue) begin
            w_r_addr       = w_snap_addr;
            w_r_addr_valid = 1'b1;
            w_replaying    = 1'b1;
        end else begin
            w_r_addr       = io_fetch.i_curr_r_addr;
            w_r_addr_valid = io_fetch.i_curr_r_addr_valid;
            w_ready        = 1'b1;
        end
    end

    assign io_fetch.o_r_addr            = w_r_addr;
    assign io_fetch.o_r_addr_valid      = w_r_addr_valid;
    assign io_fetch.o_curr_r_addr_ready = w_ready & ~i_halt;
    assign io_fetch.o_replaying         = w_replaying;

    // FSM state and replay pointer; everything freezes under halt.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
        end else if (!i_halt) begin
            r_state  <= w_next;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

`ifdef ICS1_REPLAY_STATS_EN
    logic [15:0] r_stat_miss_cnt;
    logic [15:0] r_stat_replay_cnt;

    // Saturating event counters for miss entries and replay issues.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stat_miss_cnt   <= '0;
            r_stat_replay_cnt <= '0;
        end else if (!i_halt) begin
            if (w_capture && (r_stat_miss_cnt != 16'hFFFF)) begin
                r_stat_miss_cnt <= r_stat_miss_cnt + 16'd1;
            end
            if (w_replay_issue && (r_stat_replay_cnt != 16'hFFFF)) begin
                r_stat_replay_cnt <= r_stat_replay_cnt + 16'd1;
            end
        end
    end

    assign o_stat_miss_cnt   = r_stat_miss_cnt;
    assign o_stat_replay_cnt = r_stat_replay_cnt;
`endif

endmodule

// File: tb/tb_ics1_replay_queue.sv
// Bench for ics1_replay_queue (ADDR_WIDTH=16, REPLAY_DEPTH=2). A queue-based
// model predicts the outputs every cycle; directed literal checks pin the model.
module tb_ics1_replay_queue;

    logic        clk;
    logic        arst_n;
    logic        halt;
    logic        miss;
    logic [31:0] infl_addr;
    logic [1:0]  infl_v;
    int          n_tests;
    int          n_fail;

    logic [15:0] m_pend[$];
    bit          m_in_miss;
    int          m_miss_cnt;
    int          m_rep_cnt;

    ics1_replay_queue_if #(.ADDR_WIDTH(16)) u_if ();

`ifdef ICS1_REPLAY_STATS_EN
    logic [15:0] stat_miss;
    logic [15:0] stat_rep;
`endif

    ics1_replay_queue #(
        .ADDR_WIDTH   (16),
        .REPLAY_DEPTH (2)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_halt           (halt),
        .i_inflight_addr  (infl_addr),
        .i_inflight_valid (infl_v),
        .i_miss_state     (miss),
        .io_fetch         (u_if)
`ifdef ICS1_REPLAY_STATS_EN
        ,
        .o_stat_miss_cnt   (stat_miss),
        .o_stat_replay_cnt (stat_rep)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, u_if.o_r_addr, u_if.o_r_addr_valid, u_if.o_curr_r_addr_ready, u_if.o_replaying};
    endfunction

    // Per-cycle model check at the falling edge, then advance the model to
    // what the next rising edge must do with these same inputs.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!arst_n) begin
            m_pend.delete();
            m_in_miss  = 1'b0;
            m_miss_cnt = 0;
            m_rep_cnt  = 0;
        end else begin
`ifdef ICS1_REPLAY_STATS_EN
            chk("model_stat_miss", {16'd0, stat_miss}, m_miss_cnt);
            chk("model_stat_replay", {16'd0, stat_rep}, m_rep_cnt);
`endif
            if (halt) begin
                chk("model_halt_ready", {31'd0, u_if.o_curr_r_addr_ready}, 32'd0);
            end else begin
                if (miss)
                    e = 32'd0;
                else if (m_pend.size() > 0)
                    e = {13'd0, m_pend[0], 3'b101};
                else
                    e = {13'd0, u_if.i_curr_r_addr, u_if.i_curr_r_addr_valid, 2'b10};
                chk("model_out", outs(), e);
                if (miss) begin
                    if (!m_in_miss) begin
                        m_pend.delete();
                        for (int i = 0; i < 2; i++)
                            if (infl_v[i]) m_pend.push_back(infl_addr[i*16 +: 16]);
                        m_miss_cnt++;
                    end
                    m_in_miss = 1'b1;
                end else begin
                    m_in_miss = 1'b0;
                    if (m_pend.size() > 0) begin
                        void'(m_pend.pop_front());
                        m_rep_cnt++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [15:0] a, input logic v, input logic r, input logic p);
        @(negedge clk);
        #1;
        chk(nm, outs(), {13'd0, a, v, r, p});
    endtask

    task automatic snap2(input logic [15:0] a1, input logic [15:0] a0, input logic [1:0] v);
        infl_addr = {a1, a0};
        infl_v    = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        arst_n  = 1'b0;
        halt    = 1'b0;
        miss    = 1'b0;
        infl_addr = '0;
        infl_v    = '0;
        u_if.i_curr_r_addr       = 16'h0055;
        u_if.i_curr_r_addr_valid = 1'b1;

        lit("reset_passthrough", 16'h0055, 1'b1, 1'b1, 1'b0);
`ifdef ICS1_REPLAY_STATS_EN
        chk("reset_stat_miss", {16'd0, stat_miss}, 32'd0);
        chk("reset_stat_replay", {16'd0, stat_rep}, 32'd0);
`endif
        cyc();
        arst_n = 1'b1;
        u_if.i_curr_r_addr = 16'h0040;

        for (int i = 0; i < 3; i++) begin
            lit("passthrough", 16'h0040, 1'b1, 1'b1, 1'b0);
            cyc();
        end

        // Two-entry replay; inflight garbage after entry must not be captured.
        snap2(16'h0014, 16'h0010, 2'b11);
        miss = 1'b1;
        lit("miss_block", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc();
        snap2(16'hDEAD, 16'hBEEF, 2'b11);
        for (int i = 0; i < 4; i++) cyc();
        miss = 1'b0;
        lit("replay0", 16'h0010, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("replay1", 16'h0014, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("replay_done", 16'h0040, 1'b1, 1'b1, 1'b0);
        cyc();

        // Compaction: only slice 1 valid.
        snap2(16'h0024, 16'h0099, 2'b10);
        miss = 1'b1;
        cyc(); cyc();
        miss = 1'b0;
        lit("compact", 16'h0024, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("compact_done", 16'h0040, 1'b1, 1'b1, 1'b0);
        cyc();

        // Empty snapshot: pass-through on the miss exit cycle.
        snap2(16'h1111, 16'h2222, 2'b00);
        miss = 1'b1;
        cyc(); cyc();
        miss = 1'b0;
        u_if.i_curr_r_addr = 16'h0050;
        lit("empty_exit", 16'h0050, 1'b1, 1'b1, 1'b0);
        cyc();
        u_if.i_curr_r_addr_valid = 1'b0;
        lit("pt_invalid", 16'h0050, 1'b0, 1'b1, 1'b0);
        cyc();
        u_if.i_curr_r_addr_valid = 1'b1;

        // Miss during replay: 0x0014 is dropped, new snapshot replays.
        snap2(16'h0014, 16'h0010, 2'b11);
        miss = 1'b1;
        cyc(); cyc();
        miss = 1'b0;
        lit("mdr_first", 16'h0010, 1'b1, 1'b0, 1'b1);
        cyc();
        snap2(16'h0034, 16'h0030, 2'b11);
        miss = 1'b1;
        lit("mdr_block", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        miss = 1'b0;
        lit("mdr_new0", 16'h0030, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("mdr_new1", 16'h0034, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("mdr_done", 16'h0050, 1'b1, 1'b1, 1'b0);
        cyc();

        // Halt for 3 cycles mid-replay.
        snap2(16'h0014, 16'h0010, 2'b11);
        miss = 1'b1;
        cyc(); cyc();
        miss = 1'b0;
        lit("halt_pre", 16'h0010, 1'b1, 1'b0, 1'b1);
        cyc();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        halt = 1'b0;
        lit("halt_resume", 16'h0014, 1'b1, 1'b0, 1'b1);
        cyc();
        lit("halt_done", 16'h0050, 1'b1, 1'b1, 1'b0);
`ifdef ICS1_REPLAY_STATS_EN
        chk("stat_miss_6", {16'd0, stat_miss}, 32'd6);
        chk("stat_replay_8", {16'd0, stat_rep}, 32'd8);
`endif
        cyc();

        // Reset pulse mid-replay.
        snap2(16'h0014, 16'h0010, 2'b11);
        miss = 1'b1;
        cyc(); cyc();
        miss = 1'b0;
        lit("rst_pre", 16'h0010, 1'b1, 1'b0, 1'b1);
        cyc();
        arst_n = 1'b0;
        u_if.i_curr_r_addr = 16'h0060;
        lit("rst_mid", 16'h0060, 1'b1, 1'b1, 1'b0);
`ifdef ICS1_REPLAY_STATS_EN
        chk("rst_stat_miss", {16'd0, stat_miss}, 32'd0);
        chk("rst_stat_replay", {16'd0, stat_rep}, 32'd0);
`endif
        cyc(); cyc();
        arst_n = 1'b1;
        cyc(); cyc();
        lit("rst_after", 16'h0060, 1'b1, 1'b1, 1'b0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
